// File: rtl/axi_line_master.sv
// AXI4 line master: turns one cache-line refill or writeback request into a single
// INCR burst of 64-bit beats and returns one completion to the cache controller.
module axi_line_master #(
  parameter int         LINE_BEATS = 4,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [64*LINE_BEATS-1:0] req_wline,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [64*LINE_BEATS-1:0] resp_rline,
  output logic                     resp_err,
  output logic [31:0]              araddr,
  output logic [3:0]               arid,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [63:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [3:0]               awid,
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic [1:0]               awlock,
  output logic [3:0]               awcache,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [3:0]               wid,
  output logic [63:0]              wdata,
  output logic [7:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [3:0]               bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);
  localparam int OFF = $clog2(LINE_BEATS*8);
  localparam int CW  = $clog2(LINE_BEATS+1);
  localparam int LW  = 64*LINE_BEATS;
  localparam logic [CW-1:0] LAST = CW'(LINE_BEATS-1);
  localparam logic [CW-1:0] FULL = CW'(LINE_BEATS);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          err;
  logic          aw_done;
  logic          w_done;
  logic [31:0]   addr;
  logic [LW-1:0] wline;
  logic          aw_fire;
  logic          w_fire;
  logic          unused;

  assign arid    = AXI_ID;
  assign arlen   = 8'(LINE_BEATS-1);
  assign arsize  = 3'd3;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awid    = AXI_ID;
  assign awlen   = 8'(LINE_BEATS-1);
  assign awsize  = 3'd3;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wid     = AXI_ID;
  assign wstrb   = 8'hFF;
  assign araddr  = addr;
  assign awaddr  = addr;
  assign wlast   = (cnt == LAST);
  assign resp_err = err;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign unused  = ^{rid, bid, req_addr[OFF-1:0]};

  // Beat selector for the write channel; cnt never passes LAST while writing.
  always_comb begin
    wdata = '0;
    for (int k = 0; k < LINE_BEATS; k++)
      if (cnt == CW'(k)) wdata = wline[k*64 +: 64];
  end

  // Writeback payload is plain data: captured on acceptance, no reset needed.
  always_ff @(posedge aclk) begin
    if (req_valid && req_ready) wline <= req_wline;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      arvalid    <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      rready     <= 1'b0;
      bready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rline <= '0;
      err        <= 1'b0;
      cnt        <= '0;
      addr       <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr      <= {req_addr[31:OFF], {OFF{1'b0}}};
            cnt       <= '0;
            err       <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            req_ready <= 1'b0;
            if (req_write) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WR;
            end else begin
              arvalid <= 1'b1;
              state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            for (int k = 0; k < LINE_BEATS; k++)
              if (cnt == CW'(k)) resp_rline[k*64 +: 64] <= rdata;
            // Extra beats beyond the line are dropped; cnt parks at FULL.
            if (cnt != FULL) cnt <= cnt + CW'(1);
            if (rresp != 2'b00 || cnt == FULL || (rlast && cnt != LAST)) err <= 1'b1;
            if (rlast) begin
              rready     <= 1'b0;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end
          end
        end
        S_WR: begin
          if (aw_fire) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            if (wlast) begin
              wvalid <= 1'b0;
              w_done <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          // AW and the final W may finish in either order or together.
          if ((aw_done || aw_fire) && (w_done || (w_fire && wlast))) begin
            bready <= 1'b1;
            state  <= S_B;
          end
        end
        S_B: begin
          if (bvalid) begin
            if (bresp != 2'b00) err <= 1'b1;
            bready     <= 1'b0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master: a table of line transactions run against a
// cycle-level AXI slave model, plus hand-written reset-in-burst sequences.
module tb_axi_line_master;
  localparam int LB = 4;
  localparam int LW = 64*LB;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [LW-1:0] req_wline = '0;
  logic          resp_valid, resp_ready = 1'b0, resp_err;
  logic [LW-1:0] resp_rline;
  logic [31:0]   araddr, awaddr;
  logic [3:0]    arid, awid, wid, arcache, awcache;
  logic [7:0]    arlen, awlen, wstrb;
  logic [2:0]    arsize, awsize, arprot, awprot;
  logic [1:0]    arburst, awburst, arlock, awlock;
  logic          arvalid, arready = 1'b0;
  logic [3:0]    rid = '0, bid = '0;
  logic [63:0]   rdata = '0, wdata;
  logic [1:0]    rresp = '0, bresp = '0;
  logic          rlast = 1'b0, rvalid = 1'b0, rready;
  logic          awvalid, awready = 1'b0;
  logic          wlast, wvalid, wready = 1'b0;
  logic          bvalid = 1'b0, bready;

  always #5 aclk = ~aclk;

  axi_line_master #(.LINE_BEATS(LB), .AXI_ID(4'd0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wline(req_wline),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rline(resp_rline),
    .resp_err(resp_err),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  seed;
    int          ar_dly;
    int          aw_dly;
    int          wtog;
    int          rerr_beat;
    int          nr;
    logic [1:0]  bresp;
    logic [31:0] exp_addr;
    bit          exp_err;
    int          exp_cyc;
    bit          w_first;
    int          rst_beat;
  } vec_t;

  vec_t          tbl[8];
  vec_t          hv;
  int            n_vec = 0;
  int            n_err = 0;
  logic [LW-1:0] model_rline = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic [7:0] seed, input int k);
    logic [7:0] b;
    b = 8'(int'(seed) + 17*k);
    return {8{b}};
  endfunction

  task automatic clear_slave();
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int cyc, rbeat, wbeat, ar_wait, aw_wait;
    bit r_act, ar_hs, aw_hs, b_pend, b_hs, done, stall_w;
    logic [63:0] pw;
    logic pl;
    logic [LW-1:0] wl;
    cyc = 0; rbeat = 0; wbeat = 0; ar_wait = 0; aw_wait = 0;
    r_act = 0; ar_hs = 0; aw_hs = 0; b_pend = 0; b_hs = 0; done = 0; stall_w = 0;
    pw = '0; pl = 1'b0;
    for (int k = 0; k < LB; k++) wl[k*64 +: 64] = beat(v.seed, k);
    check({tag, " req_ready idle"}, 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wline = wl; resp_ready = 1'b0;
    @(posedge aclk); #1;
    req_valid = 1'b0; req_addr = '0; req_wline = '0;
    cyc = 1;
    check({tag, " req_ready busy"}, 64'(req_ready), 64'(0));
    check({tag, " err cleared"}, 64'(resp_err), 64'(0));
    while (!done && cyc < 200) begin
      // read data channel
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      if (r_act) begin
        rvalid = 1'b1;
        rdata = beat(v.seed, rbeat);
        rresp = (rbeat == v.rerr_beat) ? 2'b10 : 2'b00;
        rlast = (rbeat == v.nr-1);
        if (rbeat == v.rst_beat) begin
          #2; aresetn = 1'b0; #1;
          check({tag, " rst valids"}, 64'({arvalid, rready, awvalid, wvalid, bready, resp_valid}), 64'(0));
          check({tag, " rst req_ready"}, 64'(req_ready), 64'(1));
          check({tag, " rst err"}, 64'(resp_err), 64'(0));
          check({tag, " rst rline"}, resp_rline[63:0], 64'(0));
          check({tag, " rst araddr"}, 64'(araddr), 64'(0));
          clear_slave();
          model_rline = '0;
          @(posedge aclk); #1;
          aresetn = 1'b1;
          @(posedge aclk); #1;
          return;
        end
        if (rready) begin
          if (rbeat < LB) model_rline[rbeat*64 +: 64] = rdata;
          rbeat++;
          if (rlast) r_act = 0;
        end
      end
      // read address channel
      check({tag, " arvalid after hs"}, 64'(arvalid & ar_hs), 64'(0));
      arready = 1'b0;
      if (arvalid) begin
        arready = (ar_wait >= v.ar_dly);
        ar_wait++;
        if (arready) begin
          check({tag, " araddr"}, 64'(araddr), 64'(v.exp_addr));
          check({tag, " ar fields"}, 64'({arid, arlen, arsize, arburst, arlock, arcache, arprot}),
                64'({4'd0, 8'd3, 3'd3, 2'b01, 2'b00, 4'd0, 3'd0}));
          ar_hs = 1; r_act = 1;
        end
      end
      // write data channel
      wready = 1'b0;
      if (wvalid) begin
        if (stall_w) begin
          check({tag, " wdata stable"}, wdata, pw);
          check({tag, " wlast stable"}, 64'(wlast), 64'(pl));
        end
        wready = (v.wtog != 0) ? ((cyc % 2) == 0) : 1'b1;
        if (wready) begin
          check({tag, " wdata"}, wdata, beat(v.seed, wbeat));
          check({tag, " wlast"}, 64'(wlast), 64'(wbeat == LB-1));
          check({tag, " w fields"}, 64'({wid, wstrb}), 64'({4'd0, 8'hFF}));
          wbeat++;
        end
        stall_w = !wready; pw = wdata; pl = wlast;
      end else if (stall_w) begin
        check({tag, " wvalid dropped"}, 64'(0), 64'(1));
        stall_w = 0;
      end
      // write address channel
      check({tag, " awvalid after hs"}, 64'(awvalid & aw_hs), 64'(0));
      awready = 1'b0;
      if (awvalid) begin
        awready = (aw_wait >= v.aw_dly);
        aw_wait++;
        if (awready) begin
          check({tag, " awaddr"}, 64'(awaddr), 64'(v.exp_addr));
          check({tag, " aw fields"}, 64'({awid, awlen, awsize, awburst, awlock, awcache, awprot}),
                64'({4'd0, 8'd3, 3'd3, 2'b01, 2'b00, 4'd0, 3'd0}));
          if (v.w_first) check({tag, " W before AW"}, 64'(wbeat), 64'(LB));
          aw_hs = 1;
        end
      end
      // write response channel
      bvalid = b_pend; bresp = v.bresp;
      if (bready) check({tag, " bready early"}, 64'(aw_hs && wbeat == LB), 64'(1));
      if (b_pend && bready) begin b_pend = 0; b_hs = 1; end
      if (v.wr && !b_hs && !b_pend && aw_hs && wbeat == LB) b_pend = 1;
      if (v.wr) check({tag, " read side idle"}, 64'({arvalid, rready}), 64'(0));
      else      check({tag, " write side idle"}, 64'({awvalid, wvalid, bready}), 64'(0));
      if (resp_valid) begin
        done = 1;
        check({tag, " resp_err"}, 64'(resp_err), 64'(v.exp_err));
        for (int k = 0; k < LB; k++)
          check({tag, $sformatf(" rline[%0d]", k)}, resp_rline[k*64 +: 64], model_rline[k*64 +: 64]);
        if (v.exp_cyc != 0) check({tag, " resp cycle"}, 64'(cyc), 64'(v.exp_cyc));
        if (v.wr) check({tag, " w beats/b"}, 64'({b_hs, 8'(wbeat)}), 64'({1'b1, 8'(LB)}));
        else      check({tag, " r beats"}, 64'(rbeat), 64'(v.nr));
        resp_ready = 1'b1;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    if (!done) check({tag, " timeout"}, 64'(0), 64'(1));
    resp_ready = 1'b0;
    clear_slave();
    check({tag, " single completion"}, 64'({resp_valid, req_ready}), 64'({1'b0, 1'b1}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //        wr addr           seed   ard awd tog rerr nr bresp exp_addr       err cyc wf rst
    tbl[0] = '{0, 32'h8000_0013, 8'h11, 0, 0, 0, -1, 4, 2'b00, 32'h8000_0000, 0, 6, 0, -1};
    tbl[1] = '{1, 32'h1234_567F, 8'hA0, 0, 3, 1, -1, 4, 2'b00, 32'h1234_5660, 0, 0, 0, -1};
    tbl[2] = '{1, 32'h0000_1FE0, 8'h05, 0, 6, 0, -1, 4, 2'b00, 32'h0000_1FE0, 0, 0, 1, -1};
    tbl[3] = '{0, 32'h4000_0108, 8'h50, 3, 0, 0,  1, 4, 2'b00, 32'h4000_0100, 1, 0, 0, -1};
    tbl[4] = '{0, 32'h4000_0200, 8'h61, 0, 0, 0, -1, 3, 2'b00, 32'h4000_0200, 1, 0, 0, -1};
    tbl[5] = '{1, 32'hFFFF_FFFF, 8'h3C, 0, 0, 0, -1, 4, 2'b10, 32'hFFFF_FFE0, 1, 0, 0, -1};
    tbl[6] = '{1, 32'h0000_0040, 8'h77, 0, 0, 0, -1, 4, 2'b00, 32'h0000_0040, 0, 6, 0, -1};
    tbl[7] = '{0, 32'h0000_0020, 8'h09, 0, 0, 0, -1, 6, 2'b00, 32'h0000_0020, 1, 0, 0, -1};

    clear_slave();
    repeat (3) @(posedge aclk);
    #1;
    check("reset valids", 64'({arvalid, rready, awvalid, wvalid, bready, resp_valid}), 64'(0));
    check("reset req_ready", 64'(req_ready), 64'(1));
    check("reset err", 64'(resp_err), 64'(0));
    check("reset rline", 64'(|resp_rline), 64'(0));
    check("reset addr", 64'({araddr, awaddr}), 64'(0));
    aresetn = 1'b1;
    @(posedge aclk); #1;

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("v%0d", i));

    // Reset while beat 2 of a refill is on the bus, then a clean refill.
    hv = '{0, 32'h2000_0000, 8'hC1, 0, 0, 0, -1, 4, 2'b00, 32'h2000_0000, 0, 0, 0, 2};
    run_txn(hv, "rst_mid_r");
    hv = '{0, 32'h2000_0031, 8'hD2, 0, 0, 0, -1, 4, 2'b00, 32'h2000_0020, 0, 6, 0, -1};
    run_txn(hv, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
